// File: rtl/switch_debounce_irq.sv
// Slide-switch conditioner: two-flop synchronizer, settle-counter debounce,
// and a sticky per-bit changed mask that drives a registered interrupt request.
module switch_debounce_irq #(
    parameter int          WIDTH           = 8,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          CNT_W           = 20,
    parameter logic [15:0] ACK_LOC         = 16'hCFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic [15:0]      cpu_addr,
    input  logic             cpu_wren,
    input  logic [15:0]      cpu_wdata,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] changed_mask,
    output logic             irq
);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sync1_q, sync2_q;
    logic [WIDTH-1:0]   snap_q, snap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sw_stable_q, sw_stable_d;
    logic [WIDTH-1:0]   changed_mask_q, changed_mask_d;
    logic               irq_q, irq_d;
    logic               commit;
    logic [WIDTH-1:0]   clr, set;

    // Upper write-data bits are not part of the acknowledge word.
    logic unused_wdata;
    assign unused_wdata = ^cpu_wdata;

    // NOTE: every register updates with <= so all flops sample pre-edge values,
    // which is what makes sync2 lag sync1 by exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sync1_q        <= '0;
            sync2_q        <= '0;
            snap_q         <= '0;
            cnt_q          <= '0;
            sw_stable_q    <= '0;
            changed_mask_q <= '0;
            irq_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sw_raw;
            sync2_q        <= sync1_q;
            snap_q         <= snap_d;
            cnt_q          <= cnt_d;
            sw_stable_q    <= sw_stable_d;
            changed_mask_q <= changed_mask_d;
            irq_q          <= irq_d;
        end
    end

    // NOTE: defaults at the top of each always_comb keep every path assigned,
    // so no latches are inferred.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync2_q != sw_stable_q) begin
                    snap_d  = sync2_q;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (sync2_q != snap_q) begin
                    snap_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A set on the commit edge overrides a same-cycle acknowledge of that bit.
    always_comb begin
        clr            = (cpu_wren && (cpu_addr == ACK_LOC)) ? cpu_wdata[WIDTH-1:0] : '0;
        set            = commit ? (snap_q ^ sw_stable_q) : '0;
        sw_stable_d    = commit ? snap_q : sw_stable_q;
        changed_mask_d = (changed_mask_q & ~clr) | set;
        irq_d          = |changed_mask_d;
    end

    assign sw_stable    = sw_stable_q;
    assign changed_mask = changed_mask_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_switch_debounce_irq.sv
// Directed and randomized bench for switch_debounce_irq with an edge-numbered
// deadline model of the debounce and acknowledge behaviour.
module tb_switch_debounce_irq;

    localparam int D = 4;

    logic        clk;
    logic        reset;
    logic [7:0]  sw_raw;
    logic [15:0] cpu_addr;
    logic        cpu_wren;
    logic [15:0] cpu_wdata;
    logic [7:0]  sw_stable;
    logic [7:0]  changed_mask;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: sync pipeline, committed value, pending target and
    // the absolute edge number at which that target commits if undisturbed.
    logic [7:0] m_sync1 = '0, m_sync2 = '0, m_stable = '0, m_mask = '0, m_target = '0;
    logic       m_irq = 1'b0, m_pending = 1'b0;
    int         m_deadline = 0;
    int         edge_n = 0;

    switch_debounce_irq #(
        .WIDTH(8), .DEBOUNCE_CYCLES(D), .CNT_W(3), .ACK_LOC(16'hCFFF)
    ) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw),
        .cpu_addr(cpu_addr), .cpu_wren(cpu_wren), .cpu_wdata(cpu_wdata),
        .sw_stable(sw_stable), .changed_mask(changed_mask), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0] clr;
        logic [7:0] set;
        clr = (cpu_wren && cpu_addr == 16'hCFFF) ? cpu_wdata[7:0] : 8'h00;
        set = 8'h00;
        edge_n++;
        if (reset) begin
            m_sync1 = '0; m_sync2 = '0; m_stable = '0; m_mask = '0;
            m_target = '0; m_irq = 1'b0; m_pending = 1'b0;
        end else begin
            if (!m_pending) begin
                if (m_sync2 != m_stable) begin
                    m_pending  = 1'b1;
                    m_target   = m_sync2;
                    m_deadline = edge_n + D;
                end
            end else if (m_sync2 != m_target) begin
                m_target   = m_sync2;
                m_deadline = edge_n + D;
            end else if (edge_n == m_deadline) begin
                set       = m_target ^ m_stable;
                m_stable  = m_target;
                m_pending = 1'b0;
            end
            m_mask  = (m_mask & ~clr) | set;
            m_irq   = (m_mask != 0);
            m_sync2 = m_sync1;
            m_sync1 = sw_raw;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_sw_stable", {8'h00, sw_stable}, {8'h00, m_stable});
        check("model_changed_mask", {8'h00, changed_mask}, {8'h00, m_mask});
        check("model_irq", {15'h0, irq}, {15'h0, m_irq});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic store(input logic [15:0] addr, input logic [15:0] data);
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_wren  = 1'b1;
        tick();
        cpu_wren  = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 16'h0000;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] st, input logic [7:0] mk, input logic iq);
        check({tag, "_sw_stable"}, {8'h00, sw_stable}, {8'h00, st});
        check({tag, "_mask"}, {8'h00, changed_mask}, {8'h00, mk});
        check({tag, "_irq"}, {15'h0, irq}, {15'h0, iq});
    endtask

    initial begin
        reset = 1'b1; sw_raw = 8'hFF;
        cpu_addr = 16'h0000; cpu_wren = 1'b0; cpu_wdata = 16'h0000;

        // Reset held two cycles with all switches high.
        tick(); expect_out("reset1", 8'h00, 8'h00, 1'b0);
        tick(); expect_out("reset2", 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        ticks(6); expect_out("post_reset_pre", 8'h00, 8'h00, 1'b0);
        tick();   expect_out("post_reset_commit", 8'hFF, 8'hFF, 1'b1);

        store(16'hCFFF, 16'h00FF); expect_out("ack_all", 8'hFF, 8'h00, 1'b0);
        sw_raw = 8'h00; ticks(7);
        store(16'hCFFF, 16'h00FF); expect_out("back_to_zero", 8'h00, 8'h00, 1'b0);

        // Clean toggle to 8'h05.
        sw_raw = 8'h05;
        ticks(6); expect_out("toggle_pre", 8'h00, 8'h00, 1'b0);
        tick();   expect_out("toggle_commit", 8'h05, 8'h05, 1'b1);

        // Acknowledge sequence, including a store to a neighbouring address.
        store(16'hCFFF, 16'h0004); expect_out("ack_bit2", 8'h05, 8'h01, 1'b1);
        store(16'hCFFE, 16'h00FF); expect_out("ack_wrong_addr", 8'h05, 8'h01, 1'b1);
        store(16'hCFFF, 16'h0001); expect_out("ack_bit0", 8'h05, 8'h00, 1'b0);

        sw_raw = 8'h00; ticks(7);
        store(16'hCFFF, 16'h00FF);

        // Bounce 01/00/01 then hold: window restarts on the last sync2 change.
        sw_raw = 8'h01; tick();
        sw_raw = 8'h00; tick();
        sw_raw = 8'h01; tick();
        ticks(5); expect_out("bounce_pre", 8'h00, 8'h00, 1'b0);
        tick();   expect_out("bounce_commit", 8'h01, 8'h01, 1'b1);
        store(16'hCFFF, 16'h0001);

        // One-cycle pulse back to the committed value: no-op commit.
        sw_raw = 8'h00; tick();
        sw_raw = 8'h01; ticks(10);
        expect_out("pulse_noop", 8'h01, 8'h00, 1'b0);

        // Commit of bit 1 coinciding with an acknowledge of bit 1.
        sw_raw = 8'h03; ticks(6);
        store(16'hCFFF, 16'h0002); expect_out("collision", 8'h03, 8'h02, 1'b1);
        store(16'hCFFF, 16'h0002); expect_out("collision_ack", 8'h03, 8'h00, 1'b0);

        // Reset two cycles into SETTLE discards the pending value.
        reset = 1'b1; sw_raw = 8'h00; ticks(2);
        reset = 1'b0; ticks(8);
        sw_raw = 8'h0A; ticks(5);
        reset = 1'b1; tick(); expect_out("mid_settle_reset", 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        ticks(6); expect_out("fresh_latency_pre", 8'h00, 8'h00, 1'b0);
        tick();   expect_out("fresh_latency_commit", 8'h0A, 8'h0A, 1'b1);

        // Randomized traffic checked against the model every cycle.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4) sw_raw = 8'($urandom);
            else if (r < 9) sw_raw = sw_raw ^ (8'h01 << $urandom_range(0, 7));
            cpu_wren  = ($urandom_range(0, 7) == 0);
            cpu_addr  = ($urandom_range(0, 3) == 0) ? 16'hCFFE : 16'hCFFF;
            cpu_wdata = 16'($urandom);
            reset     = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0; cpu_wren = 1'b0;
        ticks(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
